// File: rtl/video_fx_sequencer.sv
// Switch debounce plus pattern/fx control for the video pipeline.
// Manual or auto-stepping mode; every control change lands on a vsync leading edge.
module video_fx_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned FRAMES_PER_STEP = 120,
    parameter bit          VS_ACTIVE_HIGH  = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [3:0] i_sw_raw,
    input  logic       i_auto_raw,
    input  logic       i_vsync,
    output logic [2:0] o_pattern,
    output logic       o_fx_enable,
    output logic       o_auto_active,
    output logic       o_frame_tick,
    output logic       o_step_strobe,
    output logic [7:0] o_leds
);

    localparam int unsigned NB  = 5;
    localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned FCW = 16;
    localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_STEP - 1);

    typedef enum logic {ST_MANUAL = 1'b0, ST_AUTO = 1'b1} state_t;

    logic [NB-1:0]  r_sync1;
    logic [NB-1:0]  r_sync2;
    logic [NB-1:0]  r_deb;
    logic [DCW-1:0] r_deb_cnt [NB];

    logic           r_vs_q;
    logic           r_armed;
    logic           r_frame_tick;
    logic           w_vs_act;
    logic           w_vs_q_act;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [FCW-1:0] r_frame_cnt;
    logic [FCW-1:0] w_frame_cnt_nxt;
    logic [2:0]     r_pattern;
    logic [2:0]     w_pattern_nxt;
    logic           r_fx_enable;
    logic           w_fx_nxt;
    logic           r_step_strobe;
    logic           w_step_nxt;
    logic           r_auto_active;
    logic [7:0]     r_leds;
    logic           w_deb_auto;
    logic [3:0]     w_deb_sw;

    assign w_deb_auto = r_deb[4];
    assign w_deb_sw   = r_deb[3:0];

    // Two-flop synchronisers followed by per-bit persistence debounce
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < int'(NB); i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1 <= {i_auto_raw, i_sw_raw};
            r_sync2 <= r_sync1;
            for (int i = 0; i < int'(NB); i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] == DEB_LAST) begin
                        r_deb[i]     <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + DCW'(1);
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_vs_act   = (i_vsync == VS_ACTIVE_HIGH);
    assign w_vs_q_act = (r_vs_q == VS_ACTIVE_HIGH);

    // Leading-edge detect; r_armed suppresses a tick for a vsync already active at reset release
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_vs_q       <= ~VS_ACTIVE_HIGH;
            r_armed      <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vs_q       <= i_vsync;
            r_armed      <= r_armed | ~w_vs_act;
            r_frame_tick <= w_vs_act & ~w_vs_q_act & r_armed;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= ST_MANUAL;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_frame_tick) begin
            case (r_state)
                ST_MANUAL: if (w_deb_auto)  w_state_nxt = ST_AUTO;
                ST_AUTO:   if (!w_deb_auto) w_state_nxt = ST_MANUAL;
                default:   w_state_nxt = ST_MANUAL;
            endcase
        end
    end

    // Next control values; a mode drop on a wrap tick takes the manual load, not the step
    always_comb begin
        w_pattern_nxt   = r_pattern;
        w_fx_nxt        = r_fx_enable;
        w_frame_cnt_nxt = r_frame_cnt;
        w_step_nxt      = 1'b0;
        if (r_frame_tick) begin
            case (r_state)
                ST_MANUAL: begin
                    if (w_deb_auto) begin
                        w_frame_cnt_nxt = '0;
                    end else begin
                        w_pattern_nxt = w_deb_sw[2:0];
                        w_fx_nxt      = w_deb_sw[3];
                    end
                end
                ST_AUTO: begin
                    if (!w_deb_auto) begin
                        w_pattern_nxt = w_deb_sw[2:0];
                        w_fx_nxt      = w_deb_sw[3];
                    end else if (r_frame_cnt == FRAME_LAST) begin
                        w_frame_cnt_nxt = '0;
                        w_pattern_nxt   = r_pattern + 3'd1;
                        w_step_nxt      = 1'b1;
                        if (r_pattern == 3'd7) w_fx_nxt = ~r_fx_enable;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_frame_cnt   <= '0;
            r_pattern     <= '0;
            r_fx_enable   <= 1'b0;
            r_step_strobe <= 1'b0;
            r_auto_active <= 1'b0;
            r_leds        <= '0;
        end else begin
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_pattern     <= w_pattern_nxt;
            r_fx_enable   <= w_fx_nxt;
            r_step_strobe <= w_step_nxt;
            r_auto_active <= (w_state_nxt == ST_AUTO);
            r_leds        <= {(w_state_nxt == ST_AUTO), w_fx_nxt, 1'b0, w_pattern_nxt, 2'b00};
        end
    end

    assign o_pattern     = r_pattern;
    assign o_fx_enable   = r_fx_enable;
    assign o_auto_active = r_auto_active;
    assign o_frame_tick  = r_frame_tick;
    assign o_step_strobe = r_step_strobe;
    assign o_leds        = r_leds;

endmodule

// File: tb/tb_video_fx_sequencer.sv
// Bench for video_fx_sequencer: directed scenarios plus randomized switch/mode/reset
// activity, scored every cycle against a behavioural model of the control rules.
module tb_video_fx_sequencer;

    localparam int unsigned DEB = 4;
    localparam int unsigned FPS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       auto_raw = 1'b0;
    logic       vsync = 1'b1;
    logic [2:0] o_pattern;
    logic       o_fx_enable;
    logic       o_auto_active;
    logic       o_frame_tick;
    logic       o_step_strobe;
    logic [7:0] o_leds;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    bit vs_en = 1'b0;
    int vcnt = 0;

    always #5 clk = ~clk;

    video_fx_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .FRAMES_PER_STEP(FPS),
        .VS_ACTIVE_HIGH (1'b0)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_sw_raw     (sw),
        .i_auto_raw   (auto_raw),
        .i_vsync      (vsync),
        .o_pattern    (o_pattern),
        .o_fx_enable  (o_fx_enable),
        .o_auto_active(o_auto_active),
        .o_frame_tick (o_frame_tick),
        .o_step_strobe(o_step_strobe),
        .o_leds       (o_leds)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // 20-clk frames, vsync low for 2 clks; held high while disabled
    always @(negedge clk) begin
        if (vs_en) begin
            vcnt  = (vcnt + 1) % 20;
            vsync = !(vcnt >= 10 && vcnt < 12);
        end else begin
            vcnt  = 0;
            vsync = 1'b1;
        end
    end

    // Behavioural model state
    bit [4:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
    int       m_run [5] = '{0, 0, 0, 0, 0};
    bit       m_tick = 0, m_step = 0, m_auto = 0, m_fx = 0;
    bit [2:0] m_pat = '0;
    int       m_frames = 0;
    bit       m_prev_vs = 1, m_seen_high = 0;

    task model_step();
        bit [4:0] deb_old;
        bit       tick_old;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            m_tick = 0; m_step = 0; m_auto = 0; m_fx = 0; m_pat = '0;
            m_frames = 0; m_prev_vs = 1; m_seen_high = 0;
            return;
        end
        deb_old  = m_deb;
        tick_old = m_tick;
        m_step   = 0;
        if (tick_old) begin
            if (!m_auto) begin
                if (deb_old[4]) begin
                    m_auto = 1; m_frames = 0;
                end else begin
                    m_pat = deb_old[2:0]; m_fx = deb_old[3];
                end
            end else if (!deb_old[4]) begin
                m_auto = 0; m_pat = deb_old[2:0]; m_fx = deb_old[3];
            end else begin
                m_frames++;
                if (m_frames == int'(FPS)) begin
                    m_frames = 0;
                    m_pat    = 3'((int'(m_pat) + 1) % 8);
                    m_step   = 1;
                    if (m_pat == 3'd0) m_fx = !m_fx;
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == int'(DEB)) begin
                    m_deb[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = {auto_raw, sw};
        m_tick      = (vsync == 1'b0) && m_prev_vs && m_seen_high;
        m_seen_high = m_seen_high || vsync;
        m_prev_vs   = vsync;
    endtask

    always @(posedge clk) model_step();

    function automatic logic [14:0] exp_vec();
        return {m_pat, m_fx, m_auto, m_tick, m_step, m_auto, m_fx, 1'b0, m_pat, 2'b00};
    endfunction

    wire [14:0] dut_vec = {o_pattern, o_fx_enable, o_auto_active, o_frame_tick, o_step_strobe, o_leds};

    always @(negedge clk) if (chk_en) check_eq("cycle", 32'(dut_vec), 32'(exp_vec()));

    // Waits for a frame tick, then one more clk so the committed update is visible
    task automatic next_frame(input string tag);
        int n = 0;
        while (o_frame_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_tick_seen"}, 32'(n < 100), 32'd1);
        @(negedge clk);
    endtask

    logic [14:0] snap;

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_eq("reset_outs", 32'(dut_vec), 32'd0);

        // Manual load of debounced switches at the first boundary
        sw = 4'b1101; rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("t1_pre_pattern", 32'(o_pattern), 32'd0);
        check_eq("t1_pre_fx", 32'(o_fx_enable), 32'd0);
        vs_en = 1'b1;
        next_frame("t1");
        check_eq("t1_pattern", 32'(o_pattern), 32'd5);
        check_eq("t1_fx", 32'(o_fx_enable), 32'd1);
        check_eq("t1_leds", 32'(o_leds), 32'h54);

        // Short glitch is rejected
        sw = 4'b1100;
        repeat (3) @(negedge clk);
        sw = 4'b1101;
        next_frame("t2a");
        check_eq("t2a_pattern", 32'(o_pattern), 32'd5);
        next_frame("t2b");
        check_eq("t2b_pattern", 32'(o_pattern), 32'd5);

        // Auto stepping and fx toggle on 7->0
        sw = 4'b0110;
        next_frame("t3_load");
        check_eq("t3_load_pattern", 32'(o_pattern), 32'd6);
        auto_raw = 1'b1;
        next_frame("t3_entry");
        check_eq("t3_auto_active", 32'(o_auto_active), 32'd1);
        check_eq("t3_entry_pattern", 32'(o_pattern), 32'd6);
        next_frame("t3_a");
        next_frame("t3_b");
        check_eq("t3_no_step", 32'(o_step_strobe), 32'd0);
        next_frame("t3_c");
        check_eq("t3_step", 32'(o_step_strobe), 32'd1);
        check_eq("t3_pattern7", 32'(o_pattern), 32'd7);
        next_frame("t3_d");
        next_frame("t3_e");
        next_frame("t3_f");
        check_eq("t3_pattern0", 32'(o_pattern), 32'd0);
        check_eq("t3_fx_toggled", 32'(o_fx_enable), 32'd1);

        // Leaving auto on a wrap tick: manual load wins
        sw = 4'b0010;
        next_frame("t4_a");
        next_frame("t4_b");
        auto_raw = 1'b0;
        next_frame("t4_wrap");
        check_eq("t4_pattern", 32'(o_pattern), 32'd2);
        check_eq("t4_fx", 32'(o_fx_enable), 32'd0);
        check_eq("t4_step", 32'(o_step_strobe), 32'd0);
        check_eq("t4_auto", 32'(o_auto_active), 32'd0);

        // Mid-frame reset in auto
        sw = 4'b0100;
        next_frame("t5_load");
        check_eq("t5_pattern4", 32'(o_pattern), 32'd4);
        auto_raw = 1'b1;
        next_frame("t5_entry");
        check_eq("t5_auto", 32'(o_auto_active), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t5_reset_outs", 32'(dut_vec), 32'd0);

        // Reset released while vsync is already low: no tick
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (vsync !== 1'b0 && n < 100);
        check_eq("t5_vsync_low_seen", 32'(n < 100), 32'd1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t5_no_tick", 32'(o_frame_tick), 32'd0);
        end

        // No vsync activity: outputs hold while switches move
        next_frame("t6_pre");
        vs_en = 1'b0;
        repeat (5) @(negedge clk);
        snap = exp_vec();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if ((k % 7) == 0) begin
                sw       = 4'($urandom);
                auto_raw = 1'($urandom);
            end
        end
        check_eq("t6_hold", 32'(dut_vec), 32'(snap));
        sw = 4'b0011; auto_raw = 1'b0;
        repeat (10) @(negedge clk);
        vs_en = 1'b1;
        next_frame("t6_after");
        check_eq("t6_after_pattern", 32'(o_pattern), 32'd3);

        // Randomized activity scored by the model
        for (int it = 0; it < 150; it++) begin
            int hold;
            hold = int'($urandom_range(1, 30));
            sw   = 4'($urandom);
            if ($urandom_range(0, 3) == 0) auto_raw = ~auto_raw;
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (hold) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
